// File: rtl/aplic_gateway_sync_if.sv
// Gateway bus: raw wired sources, per-source config, software strobes and the pending/rectified results.
// Ports are grouped by the side that drives them; the master modport is the driver of the raw inputs.
interface aplic_gateway_sync_if #(
    parameter int unsigned NR_SRC = 32
);
    localparam int unsigned NR_BITS_SRC = (NR_SRC < 32) ? NR_SRC : 32;
    localparam int unsigned NR_REG      = (NR_SRC - 1) / 32;

    logic [NR_SRC-1:0]                  sources;
    logic [NR_SRC-1:1][10:0]            sourcecfg;
    logic                               domaincfg_dm;
    logic [NR_REG:0][NR_BITS_SRC-1:0]   sw_set;
    logic [NR_REG:0][NR_BITS_SRC-1:0]   sw_clr;
    logic [NR_REG:0][NR_BITS_SRC-1:0]   claimed;
    logic [NR_REG:0][NR_BITS_SRC-1:0]   intp_pen;
    logic [NR_REG:0][NR_BITS_SRC-1:0]   rectified_src;

    modport master (
        output sources, sourcecfg, domaincfg_dm, sw_set, sw_clr, claimed,
        input  intp_pen, rectified_src
    );

    modport slave (
        input  sources, sourcecfg, domaincfg_dm, sw_set, sw_clr, claimed,
        output intp_pen, rectified_src
    );
endinterface

// File: rtl/aplic_gateway_sync.sv
// APLIC domain gateway: per-source synchroniser, rectifier, edge detector and pending-state engine.
// Optional glitch filter after the synchroniser is enabled by defining APLIC_GW_FILTER_EN.
module aplic_gateway_sync #(
    parameter int unsigned NR_SRC        = 32,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    aplic_gateway_sync_if.slave bus
);
    localparam int unsigned NR_BITS_SRC = (NR_SRC < 32) ? NR_SRC : 32;
    localparam int unsigned NR_REG      = (NR_SRC - 1) / 32;
    localparam int unsigned TOT_BITS    = (NR_REG + 1) * NR_BITS_SRC;

    localparam logic [2:0] SM_DETACHED = 3'd1;
    localparam logic [2:0] SM_EDGE1    = 3'd4;
    localparam logic [2:0] SM_EDGE0    = 3'd5;
    localparam logic [2:0] SM_LEVEL1   = 3'd6;
    localparam logic [2:0] SM_LEVEL0   = 3'd7;

    logic [TOT_BITS-1:0] set_v;
    logic [TOT_BITS-1:0] clr_v;
    logic [TOT_BITS-1:0] clm_v;
    logic [NR_SRC-1:0]   src_v;
    logic [NR_SRC-1:0]   s;
    logic [NR_SRC-1:0]   f;
    logic [NR_SRC-1:0]   r_c;
    logic [NR_SRC-1:0]   edge_c;
    logic [NR_SRC-1:0]   prev_q;
    logic [NR_SRC-1:0]   pen_q;
    logic [NR_SRC-1:0]   pen_d;
    logic                cfg_unused;

    assign set_v = bus.sw_set;
    assign clr_v = bus.sw_clr;
    assign clm_v = bus.claimed;
    // Source 0 is reserved: its wire never enters the pipeline.
    assign src_v = {bus.sources[NR_SRC-1:1], 1'b0};

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign s = src_v;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][NR_SRC-1:0] chain_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    chain_q <= '0;
                end else begin
                    chain_q[0] <= src_v;
                    for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                        chain_q[k] <= chain_q[k-1];
                    end
                end
            end

            assign s = chain_q[SYNC_STAGES-1];
        end
    endgenerate

`ifdef APLIC_GW_FILTER_EN
    logic [NR_SRC-1:0]       flt_q;
    logic [NR_SRC-1:0][7:0]  cnt_q;

    // f follows s only after s has disagreed with it for FILTER_CYCLES consecutive clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_q <= '0;
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < int'(NR_SRC); i++) begin
                if (s[i] == flt_q[i]) begin
                    cnt_q[i] <= 8'd0;
                end else if (cnt_q[i] >= 8'(FILTER_CYCLES - 1)) begin
                    flt_q[i] <= s[i];
                    cnt_q[i] <= 8'd0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end
            end
        end
    end

    assign f = flt_q;
`else
    assign f = s;
`endif

    // Rectifier: delegated, detached, reserved and inactive modes read as 0.
    always_comb begin
        r_c = '0;
        for (int i = 1; i < int'(NR_SRC); i++) begin
            if (!bus.sourcecfg[i][10]) begin
                case (bus.sourcecfg[i][2:0])
                    SM_EDGE1, SM_LEVEL1: r_c[i] = f[i];
                    SM_EDGE0, SM_LEVEL0: r_c[i] = ~f[i];
                    default:             r_c[i] = 1'b0;
                endcase
            end
        end
    end

    assign edge_c = r_c & ~prev_q;

    // Pending next state; set wins over clear except the level/MSI ~r clear.
    always_comb begin
        pen_d = pen_q;
        pen_d[0] = 1'b0;
        for (int i = 1; i < int'(NR_SRC); i++) begin
            if (bus.sourcecfg[i][10]) begin
                pen_d[i] = 1'b0;
            end else begin
                case (bus.sourcecfg[i][2:0])
                    SM_DETACHED: begin
                        if (set_v[i])                     pen_d[i] = 1'b1;
                        else if (clr_v[i] | clm_v[i])     pen_d[i] = 1'b0;
                    end
                    SM_EDGE1, SM_EDGE0: begin
                        if (edge_c[i] | set_v[i])         pen_d[i] = 1'b1;
                        else if (clr_v[i] | clm_v[i])     pen_d[i] = 1'b0;
                    end
                    SM_LEVEL1, SM_LEVEL0: begin
                        if (!bus.domaincfg_dm)            pen_d[i] = r_c[i];
                        else if (!r_c[i])                 pen_d[i] = 1'b0;
                        else if (edge_c[i] | set_v[i])    pen_d[i] = 1'b1;
                        else if (clr_v[i] | clm_v[i])     pen_d[i] = 1'b0;
                    end
                    default:                              pen_d[i] = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            pen_q  <= '0;
        end else begin
            prev_q <= r_c;
            pen_q  <= pen_d;
        end
    end

    assign bus.intp_pen      = TOT_BITS'(pen_q);
    assign bus.rectified_src = TOT_BITS'(r_c);

    // Config bits [9:3], reserved bit 0 and strobe bits beyond NR_SRC carry no function.
    assign cfg_unused = ^{bus.sourcecfg, bus.sources[0], set_v, clr_v, clm_v, f[0], 8'(FILTER_CYCLES)};
endmodule

// File: tb/tb_aplic_gateway_sync.sv
// Directed self-checking bench for aplic_gateway_sync (NR_SRC=32, SYNC_STAGES=2, FILTER_CYCLES=4).
// Filter scenario runs only when APLIC_GW_FILTER_EN is defined.
module tb_aplic_gateway_sync;
    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    aplic_gateway_sync_if #(.NR_SRC(32)) bus ();

    aplic_gateway_sync #(
        .NR_SRC        (32),
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_strobes();
        bus.sw_set  = '0;
        bus.sw_clr  = '0;
        bus.claimed = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.sources = '0;
        bus.sourcecfg = '0;
        bus.domaincfg_dm = 1'b0;
        clear_strobes();
        tick(3);
        tests++;
        if (bus.intp_pen !== 32'h0) begin
            failed++;
            $display("FAIL reset_pen: got %h expected 0", bus.intp_pen);
        end
        tests++;
        if (bus.rectified_src !== 32'h0) begin
            failed++;
            $display("FAIL reset_rect: got %h expected 0", bus.rectified_src);
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    // T1: edge mode, latency and claim.
    task automatic test_edge_latency();
        bus.sourcecfg[5] = 11'h004;
        tick(1);
        bus.sources[5] = 1'b1;
        tick(1);
        chk("t1_rect_n1", bus.rectified_src[0][5], 1'b0);
        tick(1);
        chk("t1_rect_n2", bus.rectified_src[0][5], 1'b1);
        chk("t1_pen_n2", bus.intp_pen[0][5], 1'b0);
        tick(1);
        chk("t1_pen_n3", bus.intp_pen[0][5], 1'b1);
        tick(1);
        bus.claimed[0][5] = 1'b1;
        tick(1);
        bus.claimed[0][5] = 1'b0;
        chk("t1_pen_claimed", bus.intp_pen[0][5], 1'b0);
        tick(2);
        chk("t1_pen_no_reedge", bus.intp_pen[0][5], 1'b0);
        bus.sources[5] = 1'b0;
        tick(4);
        bus.sources[5] = 1'b1;
        tick(3);
        chk("t1_pen_second_edge", bus.intp_pen[0][5], 1'b1);
        bus.sources[5] = 1'b0;
        bus.sourcecfg[5] = '0;
        tick(3);
        chk("t1_pen_inactive", bus.intp_pen[0][5], 1'b0);
    endtask

    // T2: active-low level, direct delivery.
    task automatic test_level_direct();
        bus.sources[3] = 1'b0;
        bus.sourcecfg[3] = 11'h007;
        #1;
        chk("t2_rect_comb", bus.rectified_src[0][3], 1'b1);
        tick(1);
        chk("t2_pen_set", bus.intp_pen[0][3], 1'b1);
        bus.sw_clr[0][3] = 1'b1;
        tick(1);
        bus.sw_clr[0][3] = 1'b0;
        chk("t2_swclr_ignored", bus.intp_pen[0][3], 1'b1);
        bus.sources[3] = 1'b1;
        tick(2);
        chk("t2_rect_low", bus.rectified_src[0][3], 1'b0);
        chk("t2_pen_still", bus.intp_pen[0][3], 1'b1);
        tick(1);
        chk("t2_pen_clear", bus.intp_pen[0][3], 1'b0);
        bus.sources[3] = 1'b0;
        bus.sourcecfg[3] = '0;
        tick(3);
    endtask

    // T3: active-high level, MSI delivery.
    task automatic test_level_msi();
        bus.domaincfg_dm = 1'b1;
        bus.sourcecfg[7] = 11'h006;
        bus.sources[7] = 1'b1;
        tick(2);
        chk("t3_pen_n2", bus.intp_pen[0][7], 1'b0);
        tick(1);
        chk("t3_pen_set", bus.intp_pen[0][7], 1'b1);
        bus.claimed[0][7] = 1'b1;
        tick(1);
        bus.claimed[0][7] = 1'b0;
        chk("t3_pen_claimed", bus.intp_pen[0][7], 1'b0);
        tick(1);
        chk("t3_pen_stays0", bus.intp_pen[0][7], 1'b0);
        bus.sw_set[0][7] = 1'b1;
        tick(1);
        bus.sw_set[0][7] = 1'b0;
        chk("t3_pen_swset", bus.intp_pen[0][7], 1'b1);
        bus.sources[7] = 1'b0;
        tick(2);
        chk("t3_rect_low", bus.rectified_src[0][7], 1'b0);
        chk("t3_pen_before", bus.intp_pen[0][7], 1'b1);
        tick(1);
        chk("t3_pen_lowclr", bus.intp_pen[0][7], 1'b0);
        bus.sw_set[0][7] = 1'b1;
        tick(1);
        bus.sw_set[0][7] = 1'b0;
        chk("t3_notr_beats_set", bus.intp_pen[0][7], 1'b0);
        bus.sourcecfg[7] = '0;
        bus.domaincfg_dm = 1'b0;
        tick(2);
    endtask

    // T4: edge and claim collide; deactivation.
    task automatic test_edge_claim_collision();
        bus.sourcecfg[9] = 11'h004;
        bus.sources[9] = 1'b1;
        tick(2);
        bus.claimed[0][9] = 1'b1;
        tick(1);
        bus.claimed[0][9] = 1'b0;
        chk("t4_set_wins", bus.intp_pen[0][9], 1'b1);
        tick(1);
        chk("t4_pen_hold", bus.intp_pen[0][9], 1'b1);
        bus.sourcecfg[9] = '0;
        bus.sw_set[0][9] = 1'b1;
        #1;
        chk("t4_rect_inactive", bus.rectified_src[0][9], 1'b0);
        tick(1);
        bus.sw_set[0][9] = 1'b0;
        chk("t4_pen_inactive", bus.intp_pen[0][9], 1'b0);
        bus.sources[9] = 1'b0;
        tick(3);
    endtask

    // T5: detached mode and delegation.
    task automatic test_detached();
        bus.sourcecfg[2] = 11'h001;
        bus.sources[2] = 1'b1;
        tick(4);
        chk("t5_no_pen_input", bus.intp_pen[0][2], 1'b0);
        chk("t5_rect_zero", bus.rectified_src[0][2], 1'b0);
        bus.sw_set[0][2] = 1'b1;
        tick(1);
        bus.sw_set[0][2] = 1'b0;
        chk("t5_swset", bus.intp_pen[0][2], 1'b1);
        bus.sw_clr[0][2] = 1'b1;
        tick(1);
        bus.sw_clr[0][2] = 1'b0;
        chk("t5_swclr", bus.intp_pen[0][2], 1'b0);
        bus.sw_set[0][2] = 1'b1;
        bus.sw_clr[0][2] = 1'b1;
        tick(1);
        clear_strobes();
        chk("t5_set_over_clr", bus.intp_pen[0][2], 1'b1);
        bus.sw_clr[0][2] = 1'b1;
        tick(1);
        bus.sw_clr[0][2] = 1'b0;
        bus.sourcecfg[2] = 11'h401;
        bus.sw_set[0][2] = 1'b1;
        tick(1);
        bus.sw_set[0][2] = 1'b0;
        chk("t5_delegated", bus.intp_pen[0][2], 1'b0);
        bus.sourcecfg[2] = '0;
        bus.sources[2] = 1'b0;
        tick(3);
    endtask

    task automatic test_bit0();
        bus.sources[0] = 1'b1;
        bus.sw_set[0][0] = 1'b1;
        tick(4);
        bus.sw_set[0][0] = 1'b0;
        chk("bit0_pen", bus.intp_pen[0][0], 1'b0);
        chk("bit0_rect", bus.rectified_src[0][0], 1'b0);
        bus.sources[0] = 1'b0;
    endtask

    // Async reset mid-operation, then one edge for a source held high through reset.
    task automatic test_async_reset();
        bus.sourcecfg[5] = 11'h004;
        bus.sources[5] = 1'b1;
        tick(4);
        chk("ar_pen_before", bus.intp_pen[0][5], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.intp_pen !== 32'h0 || bus.rectified_src !== 32'h0) begin
            failed++;
            $display("FAIL ar_async_clear: pen %h rect %h expected 0", bus.intp_pen, bus.rectified_src);
        end
        tick(2);
        rst_n = 1'b1;
        tick(2);
        chk("ar_pen_n2", bus.intp_pen[0][5], 1'b0);
        tick(1);
        chk("ar_pen_one_edge", bus.intp_pen[0][5], 1'b1);
        bus.claimed[0][5] = 1'b1;
        tick(1);
        bus.claimed[0][5] = 1'b0;
        tick(3);
        chk("ar_no_second_edge", bus.intp_pen[0][5], 1'b0);
        bus.sourcecfg[5] = '0;
        bus.sources[5] = 1'b0;
        tick(3);
    endtask

`ifdef APLIC_GW_FILTER_EN
    // T6: glitch filter.
    task automatic test_filter();
        bus.sourcecfg[11] = 11'h004;
        bus.sources[11] = 1'b1;
        tick(3);
        bus.sources[11] = 1'b0;
        tick(10);
        chk("t6_glitch_rect", bus.rectified_src[0][11], 1'b0);
        chk("t6_glitch_pen", bus.intp_pen[0][11], 1'b0);
        bus.sources[11] = 1'b1;
        tick(5);
        chk("t6_rect_n5", bus.rectified_src[0][11], 1'b0);
        bus.sources[11] = 1'b0;
        tick(1);
        chk("t6_rect_n6", bus.rectified_src[0][11], 1'b1);
        tick(1);
        chk("t6_pen_n7", bus.intp_pen[0][11], 1'b1);
        bus.sources[11] = 1'b1;
        tick(20);
        bus.sources[11] = 1'b0;
        tick(4);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.intp_pen !== 32'h0 || bus.rectified_src !== 32'h0) begin
            failed++;
            $display("FAIL t6_reset_midcount: pen %h rect %h expected 0", bus.intp_pen, bus.rectified_src);
        end
        tick(2);
        rst_n = 1'b1;
        bus.sourcecfg[11] = '0;
        tick(3);
    endtask
`endif

    initial begin
        tests  = 0;
        failed = 0;
        rst_n  = 1'b0;
        test_reset();
        test_edge_latency();
        test_level_direct();
        test_level_msi();
        test_edge_claim_collision();
        test_detached();
        test_bit0();
        test_async_reset();
`ifdef APLIC_GW_FILTER_EN
        test_filter();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
